// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_e      : freeze sequencer states (RUN / MISS_WAIT / REFILL)
//   miss_src_e   : which cache the pending refill belongs to
//   reg_match()  : register-dependency compare used by hazard detection
package pipeline_hazard_controller_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MISS_WAIT = 2'd1,
    REFILL    = 2'd2
  } state_e;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } miss_src_e;

  // $zero is hardwired, so a write to it can never create a dependency.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_hazard_detect.sv
// Load-use hazard detector (purely combinational).
// Ports:
//   ID_EX_MemRead : instruction in EX is a load
//   ID_EX_rt      : destination register of that load
//   IF_ID_rs/rt   : source registers of the instruction in ID
//   load_use      : ID instruction consumes the load result one cycle too early
module hazard_detect_unit
  import pipeline_hazard_controller_pkg::*;
(
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_rt,
  input  logic [4:0] IF_ID_rs,
  input  logic [4:0] IF_ID_rt,
  output logic       load_use
);

  assign load_use = ID_EX_MemRead &&
                    (reg_match(ID_EX_rt, IF_ID_rs) || reg_match(ID_EX_rt, IF_ID_rt));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage MIPS pipeline.
// Ports:
//   clock, reset_n               : clock (rising edge), async active-low reset
//   icache_hit, dcache_hit       : cache hit flags (dcache_hit valid with dmem_access)
//   dmem_access                  : MEM stage issues a load/store
//   ID_EX_MemRead, ID_EX_rt      : load in EX and its destination
//   IF_ID_rs, IF_ID_rt           : sources of the instruction in ID
//   branch_taken                 : branch resolved taken in MEM
//   PC_write .. MEM_WB_hit       : pipeline register enables / flush / bubble
//   refill_icache/refill_dcache  : one-cycle line install strobes
//   busy                         : a miss sequence is in progress
//   stall_count                  : saturating count of cycles with PC_write=0
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int MISS_PENALTY = 4,
  parameter int CNT_W        = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        icache_hit,
  input  logic        dcache_hit,
  input  logic        dmem_access,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_rt,
  input  logic [4:0]  IF_ID_rs,
  input  logic [4:0]  IF_ID_rt,
  input  logic        branch_taken,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        IF_ID_flush,
  output logic        ID_EX_hit,
  output logic        ID_EX_bubble,
  output logic        EX_MEM_hit,
  output logic        EX_MEM_flush,
  output logic        MEM_WB_hit,
  output logic        refill_icache,
  output logic        refill_dcache,
  output logic        busy,
  output logic [31:0] stall_count
);

  localparam logic [CNT_W-1:0] PENALTY_LOAD = CNT_W'(MISS_PENALTY - 1);

  state_e           state, next_state;
  miss_src_e        miss_src, next_src;
  logic [CNT_W-1:0] counter, next_counter;
  logic             load_use;
  logic             dmiss, imiss;

  hazard_detect_unit u_hazard_detect (
    .ID_EX_MemRead (ID_EX_MemRead),
    .ID_EX_rt      (ID_EX_rt),
    .IF_ID_rs      (IF_ID_rs),
    .IF_ID_rt      (IF_ID_rt),
    .load_use      (load_use)
  );

  assign dmiss = dmem_access & ~dcache_hit;
  assign imiss = ~icache_hit;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of process ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RUN;
      miss_src <= ICACHE;
      counter  <= '0;
    end else begin
      state    <= next_state;
      miss_src <= next_src;
      counter  <= next_counter;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (!PC_write && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    next_state    = state;
    next_src      = miss_src;
    next_counter  = counter;
    PC_write      = 1'b0;
    IF_ID_write   = 1'b0;
    IF_ID_flush   = 1'b0;
    ID_EX_hit     = 1'b0;
    ID_EX_bubble  = 1'b0;
    EX_MEM_hit    = 1'b0;
    EX_MEM_flush  = 1'b0;
    MEM_WB_hit    = 1'b0;
    refill_icache = 1'b0;
    refill_dcache = 1'b0;
    busy          = 1'b0;

    // NOTE: outputs are combinational from the inputs in RUN, so reset must
    // gate them directly; the flops alone would not force them low.
    if (reset_n) begin
      unique case (state)
        RUN: begin
          if (dmiss || imiss) begin
            // Freeze everything this cycle; D-side wins so the I-miss is
            // picked up again on return to RUN.
            next_src     = dmiss ? DCACHE : ICACHE;
            next_counter = PENALTY_LOAD;
            next_state   = MISS_WAIT;
          end else if (branch_taken) begin
            PC_write     = 1'b1;
            IF_ID_write  = 1'b1;
            ID_EX_hit    = 1'b1;
            EX_MEM_hit   = 1'b1;
            MEM_WB_hit   = 1'b1;
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
            EX_MEM_flush = 1'b1;
          end else if (load_use) begin
            // Hold PC and IF/ID, let the load advance with a bubble behind it.
            ID_EX_hit    = 1'b1;
            EX_MEM_hit   = 1'b1;
            MEM_WB_hit   = 1'b1;
            ID_EX_bubble = 1'b1;
          end else begin
            PC_write    = 1'b1;
            IF_ID_write = 1'b1;
            ID_EX_hit   = 1'b1;
            EX_MEM_hit  = 1'b1;
            MEM_WB_hit  = 1'b1;
          end
        end
        MISS_WAIT: begin
          busy = 1'b1;
          if (counter == '0) next_state = REFILL;
          else               next_counter = counter - 1'b1;
        end
        REFILL: begin
          busy          = 1'b1;
          refill_dcache = (miss_src == DCACHE);
          refill_icache = (miss_src == ICACHE);
          next_state    = RUN;
        end
        default: next_state = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios
// followed by randomized traffic, all compared against a cycle-count model.
module tb_pipeline_hazard_controller;

  localparam int MISS_PENALTY = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        icache_hit, dcache_hit, dmem_access, ID_EX_MemRead, branch_taken;
  logic [4:0]  ID_EX_rt, IF_ID_rs, IF_ID_rt;
  logic        PC_write, IF_ID_write, IF_ID_flush, ID_EX_hit, ID_EX_bubble;
  logic        EX_MEM_hit, EX_MEM_flush, MEM_WB_hit;
  logic        refill_icache, refill_dcache, busy;
  logic [31:0] stall_count;

  pipeline_hazard_controller #(.MISS_PENALTY(MISS_PENALTY), .CNT_W(8)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .icache_hit    (icache_hit),
    .dcache_hit    (dcache_hit),
    .dmem_access   (dmem_access),
    .ID_EX_MemRead (ID_EX_MemRead),
    .ID_EX_rt      (ID_EX_rt),
    .IF_ID_rs      (IF_ID_rs),
    .IF_ID_rt      (IF_ID_rt),
    .branch_taken  (branch_taken),
    .PC_write      (PC_write),
    .IF_ID_write   (IF_ID_write),
    .IF_ID_flush   (IF_ID_flush),
    .ID_EX_hit     (ID_EX_hit),
    .ID_EX_bubble  (ID_EX_bubble),
    .EX_MEM_hit    (EX_MEM_hit),
    .EX_MEM_flush  (EX_MEM_flush),
    .MEM_WB_hit    (MEM_WB_hit),
    .refill_icache (refill_icache),
    .refill_dcache (refill_dcache),
    .busy          (busy),
    .stall_count   (stall_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: frozen cycles still owed after the current one, and
  // whether the pending refill is for the D-cache.
  int      frz_left = 0;
  logic    src_d    = 1'b0;
  longint  stall_m  = 0;
  int      rsv_refill_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Output vector order:
  // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_hit, ID_EX_bubble, EX_MEM_hit,
  //  EX_MEM_flush, MEM_WB_hit, refill_icache, refill_dcache, busy}
  function automatic logic [10:0] dut_vec();
    return {PC_write, IF_ID_write, IF_ID_flush, ID_EX_hit, ID_EX_bubble, EX_MEM_hit,
            EX_MEM_flush, MEM_WB_hit, refill_icache, refill_dcache, busy};
  endfunction

  // One clock cycle: drive inputs at the falling edge, compare, then let the
  // rising edge happen and advance the model.
  task automatic apply(input logic rst, input logic ic, input logic dc, input logic da,
                       input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] rt, input logic br);
    logic [10:0] exp_v;
    logic        dm, im, lu, miss_now;
    @(negedge clock);
    reset_n = rst; icache_hit = ic; dcache_hit = dc; dmem_access = da;
    ID_EX_MemRead = mr; ID_EX_rt = ert; IF_ID_rs = rs; IF_ID_rt = rt; branch_taken = br;
    if (!rst) begin
      frz_left = 0;
      stall_m  = 0;
    end
    #1;
    dm = da && !dc;
    im = !ic;
    lu = mr && (ert != 5'd0) && ((ert == rs) || (ert == rt));
    miss_now = 1'b0;
    if (!rst)               exp_v = '0;
    else if (frz_left > 0)  exp_v = {8'b0, (frz_left == 1) && !src_d, (frz_left == 1) && src_d, 1'b1};
    else if (dm || im) begin
      exp_v = '0;
      miss_now = 1'b1;
    end
    else if (br)            exp_v = 11'b111_1111_1000;
    else if (lu)            exp_v = 11'b000_1110_1000;
    else                    exp_v = 11'b110_1010_1000;
    check("ctl", 32'(dut_vec()), 32'(exp_v));
    check("stall_count", stall_count, 32'(stall_m));
    if (refill_icache || refill_dcache) rsv_refill_seen++;
    @(posedge clock);
    if (rst) begin
      if (!exp_v[10] && stall_m < 64'hFFFF_FFFF) stall_m++;
      if (miss_now) begin
        frz_left = MISS_PENALTY + 1;
        src_d    = dm;
      end else if (frz_left > 0) begin
        frz_left--;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask

  initial begin
    int base;
    reset_n = 1'b0; icache_hit = 1'b0; dcache_hit = 1'b1; dmem_access = 1'b0;
    ID_EX_MemRead = 1'b0; ID_EX_rt = '0; IF_ID_rs = '0; IF_ID_rt = '0; branch_taken = 1'b0;
    rsv_refill_seen = 0;

    // Reset held with a pending I-miss, then release straight into the miss.
    for (int i = 0; i < 3; i++) apply(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    apply(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    for (int i = 0; i < 5; i++) apply(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    check("imiss_stall_total", stall_count, 32'd6);
    check("imiss_refills", 32'(rsv_refill_seen), 32'd1);
    idle(2);

    // Simultaneous D- and I-miss: two back-to-back sequences.
    base = int'(stall_count);
    apply(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    for (int i = 0; i < 5; i++) apply(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    apply(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    for (int i = 0; i < 5; i++) apply(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    check("dual_miss_stalls", stall_count - 32'(base), 32'd12);
    idle(1);

    // Load-use on rs, then the same with $zero as destination.
    base = int'(stall_count);
    apply(1, 1, 1, 0, 1, 5'd5, 5'd5, 5'd1, 0);
    check("load_use_stall", stall_count - 32'(base), 32'd1);
    apply(1, 1, 1, 0, 1, 5'd0, 5'd0, 5'd0, 0);
    apply(1, 1, 1, 0, 1, 5'd7, 5'd2, 5'd7, 0);
    check("load_use_rt_zero", stall_count - 32'(base), 32'd2);

    // Branch overrides load-use.
    base = int'(stall_count);
    apply(1, 1, 1, 0, 1, 5'd5, 5'd5, 5'd5, 1);
    check("branch_no_stall", stall_count - 32'(base), 32'd0);

    // Reset two cycles into MISS_WAIT aborts the sequence.
    rsv_refill_seen = 0;
    apply(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    apply(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    apply(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    apply(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(6);
    check("abort_no_refill", 32'(rsv_refill_seen), 32'd0);
    check("abort_stall_count", stall_count, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 59) != 0),
            ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 5) != 0),
            1'($urandom),
            1'($urandom),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            ($urandom_range(0, 5) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
